thermometer2binary_pipe: RTL and testbench

Streaming decoder that converts LSB-filled thermometer codes back to binary counts. It is the receive-side counterpart of the binary-to-thermometer encoder, used where thermometer-coded values (DAC segment selects, comparator-ladder snapshots) must be read back.
- Two-stage valid/ready pipeline.
- Detects non-monotonic ("bubble") codes, flags them per item and keeps a saturating error counter.

---
 rtl/thermometer_pkg.sv | 46 ++++
 rtl/thermometer2binary_decode.sv | 39 +++
 rtl/thermometer2binary_pipe.sv | 104 ++++++++++
 tb/tb_thermometer2binary_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/thermometer_pkg.sv
// Shared helpers for thermometer-code encode/decode blocks: widths, bubble test and
// the two decode rules, usable from RTL and benches alike.
package thermometer_pkg;

  localparam int MAX_WIDTH = 64;

  typedef logic [MAX_WIDTH-1:0] code_t;

  typedef enum logic [0:0] {
    DEC_COUNT = 1'b0,
    DEC_MSB   = 1'b1
  } dec_rule_e;

  function automatic int bin_width(input int width);
    return $clog2(width + 1);
  endfunction

  // A legal code is a run of ones from bit 0; any 0 directly below a 1 breaks it.
  function automatic logic is_bubble(input code_t code, input int width);
    logic b;
    b = 1'b0;
    for (int i = 0; i < MAX_WIDTH - 1; i++) begin
      if (i < width - 1) b = b | (~code[i] & code[i+1]);
    end
    return b;
  endfunction

  function automatic int popcount(input code_t code, input int width);
    int n;
    n = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) n = n + int'(code[i]);
    end
    return n;
  endfunction

  function automatic int msb_plus_one(input code_t code, input int width);
    int n;
    n = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width && code[i]) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/thermometer2binary_decode.sv
// Combinational thermometer-to-binary decode with bubble detection; the decode
// rule is fixed at elaboration.
module thermometer2binary_decode
  import thermometer_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter     IMPLEMENTATION = "COUNT",
  localparam int BW            = bin_width(WIDTH)
) (
  input  logic [WIDTH-1:0] code_i,
  output logic [BW-1:0]    binary_o,
  output logic             bubble_o
);

  localparam dec_rule_e RULE = (IMPLEMENTATION == "MSB") ? DEC_MSB : DEC_COUNT;

  if (IMPLEMENTATION != "COUNT" && IMPLEMENTATION != "MSB") begin : g_bad_impl
    $error("thermometer2binary_decode: IMPLEMENTATION must be \"COUNT\" or \"MSB\"");
  end

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("thermometer2binary_decode: WIDTH out of supported range");
  end

  code_t code_ext;

  assign code_ext = code_t'(code_i);

  always_comb begin
    binary_o = '0;
    if (RULE == DEC_MSB) begin
      binary_o = BW'(msb_plus_one(code_ext, WIDTH));
    end else begin
      binary_o = BW'(popcount(code_ext, WIDTH));
    end
    bubble_o = is_bubble(code_ext, WIDTH);
  end

endmodule

// File: rtl/thermometer2binary_pipe.sv
// Two-stage valid/ready thermometer-to-binary decoder with per-item bubble flag
// and a saturating count of delivered bubble results.
module thermometer2binary_pipe
  import thermometer_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter     IMPLEMENTATION = "COUNT",
  parameter int CNT_WIDTH      = 8,
  localparam int BW            = bin_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_thermometer,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW-1:0]        out_binary,
  output logic                 out_bubble,
  input  logic                 err_clear,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [CNT_WIDTH-1:0] ERR_MAX = '1;

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_code_q;
  logic                 s1_bubble_q;
  logic                 out_valid_q, out_valid_d;
  logic [BW-1:0]        out_binary_q, out_binary_d;
  logic                 out_bubble_q, out_bubble_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic          s2_ready;
  logic          s1_load;
  logic          s2_load;
  logic          out_xfer;
  logic [BW-1:0] dec_binary;
  logic          dec_bubble;

  // Ready ripples combinationally from the output back to the input.
  assign s2_ready = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_ready;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & s2_ready;
  assign out_xfer = out_valid_q & out_ready;

  // ---- stage 1: capture code and its bubble flag ----
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_code_q   <= in_thermometer;
      s1_bubble_q <= is_bubble(code_t'(in_thermometer), WIDTH);
    end
  end

  thermometer2binary_decode #(
    .WIDTH         (WIDTH),
    .IMPLEMENTATION(IMPLEMENTATION)
  ) u_decode (
    .code_i  (s1_code_q),
    .binary_o(dec_binary),
    .bubble_o(dec_bubble)
  );

  always_comb begin
    s1_valid_d   = s1_load | (s1_valid_q & ~s2_ready);
    out_valid_d  = s2_load | (out_valid_q & ~out_ready);
    out_binary_d = out_binary_q;
    out_bubble_d = out_bubble_q;
    if (s2_load) begin
      out_binary_d = dec_binary;
      out_bubble_d = s1_bubble_q | dec_bubble;
    end
    err_count_d = err_count_q;
    if (err_clear) begin
      err_count_d = '0;
    end else if (out_xfer && out_bubble_q && err_count_q != ERR_MAX) begin
      err_count_d = err_count_q + CNT_WIDTH'(1);
    end
  end

  // ---- stage 2: decoded result held until accepted ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_binary_q <= '0;
      out_bubble_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_binary_q <= out_binary_d;
      out_bubble_q <= out_bubble_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_binary = out_binary_q;
  assign out_bubble = out_bubble_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_thermometer2binary_pipe.sv
// Scoreboard bench: one COUNT and one MSB decoder share the stimulus; a monitor
// pops expected results whenever an output transfer happens.
module tb_thermometer2binary_pipe;

  localparam int WIDTH = 4;
  localparam int BW    = 3;
  localparam int CW    = 2;
  localparam int ERR_SAT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             out_ready;
  logic             err_clear;
  logic [WIDTH-1:0] in_thermometer;

  logic          rdy_c, rdy_m, ov_c, ov_m, bub_c, bub_m;
  logic [BW-1:0] bin_c, bin_m;
  logic [CW-1:0] err_c, err_m;

  always #5 clk = ~clk;

  thermometer2binary_pipe #(
    .WIDTH(WIDTH), .IMPLEMENTATION("COUNT"), .CNT_WIDTH(CW)
  ) u_cnt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
    .in_thermometer(in_thermometer), .out_valid(ov_c), .out_ready(out_ready),
    .out_binary(bin_c), .out_bubble(bub_c), .err_clear(err_clear), .err_count(err_c)
  );

  thermometer2binary_pipe #(
    .WIDTH(WIDTH), .IMPLEMENTATION("MSB"), .CNT_WIDTH(CW)
  ) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m),
    .in_thermometer(in_thermometer), .out_valid(ov_m), .out_ready(out_ready),
    .out_binary(bin_m), .out_bubble(bub_m), .err_clear(err_clear), .err_count(err_m)
  );

  typedef struct {
    logic [WIDTH-1:0] code;
    int               cnt;
    int               msb;
    logic             bub;
    int               issue;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one code (called at posedge+1) and holds it until accepted.
  task automatic send(input logic [WIDTH-1:0] code, input int cnt, input int msb,
                      input logic bub, input bit lat);
    exp_t e;
    int   issue;
    bit   acc;
    in_valid       = 1'b1;
    in_thermometer = code;
    issue          = cyc;
    acc            = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      if (rdy_c) begin
        acc = 1'b1;
        e   = '{code, cnt, msb, bub, issue, lat};
        sb.push_back(e);
      end
      tick();
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: code %b never accepted, expected acceptance", code);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: checks every delivered result and tracks the expected error count.
  always @(negedge clk) begin
    if (rst) begin
      exp_err = 0;
    end else begin
      chk("err_count_cnt", 32'(err_c), exp_err);
      chk("err_count_msb", 32'(err_m), exp_err);
      if (ov_c && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got binary %0d, expected no output", bin_c);
        end else begin
          mon_e = sb.pop_front();
          chk("out_valid_msb", 32'(ov_m), 1);
          chk("out_binary_count", 32'(bin_c), mon_e.cnt);
          chk("out_binary_msb", 32'(bin_m), mon_e.msb);
          chk("out_bubble_cnt", 32'(bub_c), 32'(mon_e.bub));
          chk("out_bubble_msb", 32'(bub_m), 32'(mon_e.bub));
          if (mon_e.lat) chk("latency", cyc - mon_e.issue, 2);
          if (mon_e.bub && exp_err < ERR_SAT) exp_err++;
        end
      end
      if (err_clear) exp_err = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] legal_codes [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
  logic [WIDTH-1:0] bub_codes   [5] = '{4'b0101, 4'b0010, 4'b1001, 4'b0110, 4'b1010};
  int               bub_cnt     [5] = '{2, 1, 2, 2, 2};
  int               bub_msb     [5] = '{3, 2, 4, 3, 4};

  initial begin
    bit seen;
    rst            = 1'b1;
    in_valid       = 1'b1;
    in_thermometer = 4'b1111;
    out_ready      = 1'b1;
    err_clear      = 1'b0;

    // Reset held two edges with in_valid high
    tick();
    tick();
    chk("reset_out_valid_cnt", 32'(ov_c), 0);
    chk("reset_out_valid_msb", 32'(ov_m), 0);
    chk("reset_err_count", 32'(err_c), 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(rdy_c), 1);
    tick();

    // Legal codes back to back, latency 2
    for (int i = 0; i < 5; i++) send(legal_codes[i], i, i, 1'b0, 1'b1);
    repeat (4) tick();

    // Bubble code 0101: COUNT=2, MSB=3
    send(4'b0101, 2, 3, 1'b1, 1'b1);
    repeat (4) tick();
    chk("err_after_first_bubble", 32'(err_c), 1);

    // Backpressure
    out_ready = 1'b0;
    send(4'b0001, 1, 1, 1'b0, 1'b0);
    send(4'b0011, 2, 2, 1'b0, 1'b0);
    fork
      send(4'b0111, 3, 3, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(rdy_c), 0);
          chk("stall_out_valid", 32'(ov_c), 1);
          chk("stall_out_binary", 32'(bin_c), 1);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (5) tick();
    chk("in_ready_after_drain", 32'(rdy_c), 1);
    chk("drained_after_backpressure", sb.size(), 0);

    // Saturation of the error counter, then clear colliding with a bubble transfer
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    for (int i = 0; i < 5; i++) send(bub_codes[i], bub_cnt[i], bub_msb[i], 1'b1, 1'b1);
    repeat (4) tick();
    chk("err_saturated_cnt", 32'(err_c), ERR_SAT);
    chk("err_saturated_msb", 32'(err_m), ERR_SAT);
    out_ready = 1'b0;
    send(4'b1011, 3, 4, 1'b1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (ov_c) seen = 1'b1;
    end
    chk("held_bubble_visible", 32'(seen), 1);
    tick();
    err_clear = 1'b1;
    out_ready = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clear_beats_increment", 32'(err_c), 0);

    // Reset with two items in flight
    out_ready = 1'b0;
    send(4'b0001, 1, 1, 1'b0, 1'b0);
    send(4'b0011, 2, 2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("midstream_reset_out_valid_cnt", 32'(ov_c), 0);
    chk("midstream_reset_out_valid_msb", 32'(ov_m), 0);
    sb.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    send(4'b1111, 4, 4, 1'b0, 1'b1);
    send(4'b0000, 0, 0, 1'b0, 1'b1);
    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
